// File: rtl/perf_cntr_readout_if.sv
`default_nettype none
// ============================================================================
// Module   : perf_cntr_readout_if
// Brief    : CPU-side read bus for the performance-counter snapshot readout.
// Revision : 1.0
// ============================================================================
interface perf_cntr_readout_if;
    logic        rd_req;
    logic [15:0] operand_in;
    logic        rd_ack;
    logic        rd_err;
    logic [31:0] perf_cntr_out;

    modport master (
        output rd_req, operand_in,
        input  rd_ack, rd_err, perf_cntr_out
    );

    modport slave (
        input  rd_req, operand_in,
        output rd_ack, rd_err, perf_cntr_out
    );
endinterface
`default_nettype wire

// File: rtl/perf_cntr_readout.sv
`default_nettype none
// ============================================================================
// Module   : perf_cntr_readout
// Brief    : Delayed coherent snapshot of performance totals, served as
//            32-bit words with a high-half latch for torn-free 64-bit reads.
// Revision : 1.0
// ============================================================================
module perf_cntr_readout #(
    parameter int SNAP_DELAY = 2,
    parameter int SNAP_CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                perf_start,
    input  logic                perf_end,
    input  logic [63:0]         total_cycle,
    input  logic [63:0]         total_ex_insn,
    input  logic [63:0]         dcache_miss_total_count,
    input  logic [63:0]         dcache_hit_total_count,
    input  logic [63:0]         dcache_wb_total_count,
    input  logic [63:0]         dcache_flush_total_count,
    input  logic [63:0]         seedcache_access_total_count,
    input  logic [63:0]         seedcache_miss_total_count,
    input  logic [63:0]         seedcache_hit_total_count,
    input  logic [63:0]         seedcache_wb_total_count,
    input  logic [31:0]         load_enc_stall_cycle,
    input  logic [31:0]         store_enc_stall_cycle,
    perf_cntr_readout_if.slave  rd_bus,
    output logic                snap_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [2:0] c_DLY_LOAD   = 3'(SNAP_DELAY - 1);
    localparam logic [3:0] c_IDX_LAST64 = 4'd9;
    localparam logic [3:0] c_IDX_LOAD   = 4'd10;
    localparam logic [3:0] c_IDX_STORE  = 4'd11;
    localparam logic [3:0] c_IDX_STATUS = 4'd12;

    state_t                  r_state, w_state_nxt;
    logic [2:0]              r_dly;
    logic                    w_capture;
    logic [63:0]             r_shadow [0:9];
    logic [63:0]             w_tot    [0:9];
    logic [31:0]             r_load_stall, r_store_stall;
    logic [SNAP_CNT_W-1:0]   r_snap_cnt;
    logic                    r_snap_valid;
    logic                    r_err_sticky;
    logic [31:0]             r_hi_latch;
    logic [3:0]              r_latch_idx;
    logic                    r_latch_vld;
    logic                    r_pend;
    logic [4:0]              r_sel;
    logic                    r_ack, r_err;
    logic [31:0]             r_data;
    logic [4:0]              w_sel;
    logic [3:0]              w_idx;
    logic                    w_hi;
    logic [31:0]             w_rd_data;
    logic                    w_ack, w_err, w_serve, w_pend_nxt;
    logic                    w_unused_sel;

    assign w_unused_sel = ^rd_bus.operand_in[15:5];

    assign w_tot[0] = total_cycle;
    assign w_tot[1] = total_ex_insn;
    assign w_tot[2] = dcache_miss_total_count;
    assign w_tot[3] = dcache_hit_total_count;
    assign w_tot[4] = dcache_wb_total_count;
    assign w_tot[5] = dcache_flush_total_count;
    assign w_tot[6] = seedcache_access_total_count;
    assign w_tot[7] = seedcache_miss_total_count;
    assign w_tot[8] = seedcache_hit_total_count;
    assign w_tot[9] = seedcache_wb_total_count;

    // perf_start overrides everything; a fresh perf_end restarts the countdown
    assign w_capture = !perf_start && !perf_end && (r_state == WAIT) && (r_dly == 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (perf_start)      w_state_nxt = IDLE;
        else if (perf_end)   w_state_nxt = WAIT;
        else if (w_capture)  w_state_nxt = READY;
    end

    // A pending read keeps its registered selector; otherwise decode the live request
    assign w_sel = r_pend ? r_sel : rd_bus.operand_in[4:0];
    assign w_idx = w_sel[4:1];
    assign w_hi  = w_sel[0];

    always_comb begin
        w_rd_data = '0;
        if (w_idx <= c_IDX_LAST64) begin
            if (!w_hi)
                w_rd_data = r_shadow[w_idx][31:0];
            else if (r_latch_vld && (r_latch_idx == w_idx))
                w_rd_data = r_hi_latch;
            else
                w_rd_data = r_shadow[w_idx][63:32];
        end else if (!w_hi) begin
            if (w_idx == c_IDX_LOAD)        w_rd_data = r_load_stall;
            else if (w_idx == c_IDX_STORE)  w_rd_data = r_store_stall;
            else if (w_idx == c_IDX_STATUS)
                w_rd_data = {16'b0, 8'(r_snap_cnt), 5'b0,
                             r_err_sticky, (r_state == WAIT), r_snap_valid};
        end
    end

    always_comb begin
        w_ack      = 1'b0;
        w_err      = 1'b0;
        w_serve    = 1'b0;
        w_pend_nxt = r_pend;
        if (r_pend) begin
            if (perf_start || (r_state == IDLE)) begin
                w_ack = 1'b1; w_err = 1'b1; w_pend_nxt = 1'b0;
            end else if (r_state == READY) begin
                w_ack = 1'b1; w_serve = 1'b1; w_pend_nxt = 1'b0;
            end
        end else if (rd_bus.rd_req) begin
            if (w_idx > c_IDX_STATUS) begin
                w_ack = 1'b1; w_err = 1'b1;
            end else if ((w_idx == c_IDX_STATUS) || (r_state == READY)) begin
                w_ack = 1'b1; w_serve = 1'b1;
            end else if ((r_state == WAIT) && !perf_start) begin
                w_pend_nxt = 1'b1;
            end else begin
                w_ack = 1'b1; w_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dly         <= '0;
            r_snap_cnt    <= '0;
            r_snap_valid  <= 1'b0;
            r_load_stall  <= '0;
            r_store_stall <= '0;
            for (int i = 0; i < 10; i++) r_shadow[i] <= '0;
        end else begin
            if (perf_end && !perf_start)
                r_dly <= c_DLY_LOAD;
            else if ((r_state == WAIT) && (r_dly != 3'd0))
                r_dly <= r_dly - 3'd1;

            if (perf_start)     r_snap_valid <= 1'b0;
            else if (w_capture) r_snap_valid <= 1'b1;

            if (w_capture) begin
                r_snap_cnt    <= r_snap_cnt + 1'b1;
                r_load_stall  <= load_enc_stall_cycle;
                r_store_stall <= store_enc_stall_cycle;
                for (int i = 0; i < 10; i++) r_shadow[i] <= w_tot[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend       <= 1'b0;
            r_sel        <= '0;
            r_ack        <= 1'b0;
            r_err        <= 1'b0;
            r_data       <= '0;
            r_err_sticky <= 1'b0;
            r_hi_latch   <= '0;
            r_latch_idx  <= '0;
            r_latch_vld  <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_ack  <= w_ack;
            r_err  <= w_err;
            if (!r_pend && rd_bus.rd_req) r_sel  <= rd_bus.operand_in[4:0];
            if (w_ack)                    r_data <= w_serve ? w_rd_data : 32'd0;

            if (perf_start)
                r_err_sticky <= 1'b0;
            else if (w_ack && w_err)
                r_err_sticky <= 1'b1;
            else if (w_serve && (w_idx == c_IDX_STATUS))
                r_err_sticky <= 1'b0;

            // Low-half read freezes the matching high word for the follow-up read
            if (perf_start || w_capture) begin
                r_latch_vld <= 1'b0;
            end else if (w_serve && !w_hi && (w_idx <= c_IDX_LAST64)) begin
                r_hi_latch  <= r_shadow[w_idx][63:32];
                r_latch_idx <= w_idx;
                r_latch_vld <= 1'b1;
            end
        end
    end

    assign rd_bus.rd_ack        = r_ack;
    assign rd_bus.rd_err        = r_err;
    assign rd_bus.perf_cntr_out = r_data;
    assign snap_valid           = r_snap_valid;

endmodule
`default_nettype wire

// File: tb/tb_perf_cntr_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_perf_cntr_readout
// Brief    : Directed self-checking bench for perf_cntr_readout.
// Revision : 1.0
// ============================================================================
module tb_perf_cntr_readout;

    logic        clk = 1'b0;
    logic        rst;
    logic        perf_start, perf_end;
    logic [63:0] total_cycle, total_ex_insn;
    logic [63:0] dmiss, dhit, dwb, dflush, sacc, smiss, shit, swb;
    logic [31:0] ld_stall, st_stall;
    logic        snap_valid;
    int          n_checks = 0;
    int          n_fail   = 0;

    perf_cntr_readout_if bus ();

    perf_cntr_readout #(.SNAP_DELAY(2), .SNAP_CNT_W(8)) dut (
        .clk                          (clk),
        .rst                          (rst),
        .perf_start                   (perf_start),
        .perf_end                     (perf_end),
        .total_cycle                  (total_cycle),
        .total_ex_insn                (total_ex_insn),
        .dcache_miss_total_count      (dmiss),
        .dcache_hit_total_count       (dhit),
        .dcache_wb_total_count        (dwb),
        .dcache_flush_total_count     (dflush),
        .seedcache_access_total_count (sacc),
        .seedcache_miss_total_count   (smiss),
        .seedcache_hit_total_count    (shit),
        .seedcache_wb_total_count     (swb),
        .load_enc_stall_cycle         (ld_stall),
        .store_enc_stall_cycle        (st_stall),
        .rd_bus                       (bus),
        .snap_valid                   (snap_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the ack is checked at the following negedge
    task automatic rd(input logic [15:0] sel, input logic [31:0] exp_d,
                      input logic exp_e, input string tag);
        bus.rd_req     = 1'b1;
        bus.operand_in = sel;
        @(negedge clk);
        bus.rd_req = 1'b0;
        chk({tag, "_ack"},  64'(bus.rd_ack),        64'd1);
        chk({tag, "_err"},  64'(bus.rd_err),        64'(exp_e));
        chk({tag, "_data"}, 64'(bus.perf_cntr_out), 64'(exp_d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; perf_start = 1'b0; perf_end = 1'b0;
        bus.rd_req = 1'b0; bus.operand_in = '0;
        total_cycle   = 64'h0000_0001_2345_6789;
        total_ex_insn = 64'h0000_0000_0000_1000;
        dmiss  = 64'h0000_0002_0000_0010;  dhit  = 64'h0000_0003_0000_0020;
        dwb    = 64'h0000_0004_0000_0030;  dflush = 64'h0000_0005_0000_0040;
        sacc   = 64'h0000_0006_0000_0050;  smiss = 64'h0000_0007_0000_0060;
        shit   = 64'h0000_0008_0000_0070;  swb   = 64'h0000_0009_0000_0080;
        ld_stall = 32'hDEAD_0001;          st_stall = 32'hBEEF_0002;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_sv",   64'(snap_valid),        64'd0);
        chk("rst_ack",  64'(bus.rd_ack),        64'd0);
        chk("rst_err",  64'(bus.rd_err),        64'd0);
        chk("rst_data", 64'(bus.perf_cntr_out), 64'd0);

        rd(16'h0000, 32'h0, 1'b1, "idle_rd");
        chk("idle_sv", 64'(snap_valid), 64'd0);

        // First snapshot: snap_valid three cycles after perf_end
        perf_end = 1'b1;
        @(negedge clk); perf_end = 1'b0;
        chk("sv_d1", 64'(snap_valid), 64'd0);
        @(negedge clk);
        chk("sv_d2", 64'(snap_valid), 64'd0);
        @(negedge clk);
        chk("sv_d3", 64'(snap_valid), 64'd1);

        rd(16'h0000, 32'h2345_6789, 1'b0, "cyc_lo");
        rd(16'h0001, 32'h0000_0001, 1'b0, "cyc_hi");
        rd(16'h0003, 32'h0000_0000, 1'b0, "insn_hi");
        rd(16'h0005, 32'h0000_0002, 1'b0, "dmiss_hi");
        rd(16'h0012, 32'h0000_0080, 1'b0, "swb_lo");
        rd(16'h0013, 32'h0000_0009, 1'b0, "swb_hi");
        rd(16'h0014, 32'hDEAD_0001, 1'b0, "ld_lo");
        rd(16'h0015, 32'h0000_0000, 1'b0, "ld_hi");
        rd(16'h0016, 32'hBEEF_0002, 1'b0, "st_lo");
        rd(16'h0017, 32'h0000_0000, 1'b0, "st_hi");
        rd(16'hFFE0, 32'h2345_6789, 1'b0, "sel_upper_ignored");
        rd(16'h0018, 32'h0000_0105, 1'b0, "status1");
        rd(16'h0018, 32'h0000_0101, 1'b0, "status2");
        rd(16'h0019, 32'h0000_0000, 1'b0, "status_hi");

        // Coherence: high read overlapping the next perf_end returns old word
        rd(16'h0000, 32'h2345_6789, 1'b0, "coh_lo");
        total_cycle = 64'h0000_0007_89AB_CDEF;
        bus.rd_req = 1'b1; bus.operand_in = 16'h0001; perf_end = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0; perf_end = 1'b0;
        chk("coh_hi_ack",  64'(bus.rd_ack),        64'd1);
        chk("coh_hi_data", 64'(bus.perf_cntr_out), 64'h0000_0001);
        repeat (2) @(negedge clk);
        rd(16'h0001, 32'h0000_0007, 1'b0, "coh_new_hi");
        rd(16'h0000, 32'h89AB_CDEF, 1'b0, "coh_new_lo");

        // Read issued during WAIT is deferred to the cycle after capture
        dhit = 64'h0000_0055_1234_ABCD;
        perf_end = 1'b1;
        @(negedge clk);
        perf_end = 1'b0; bus.rd_req = 1'b1; bus.operand_in = 16'h0006;
        @(negedge clk);
        bus.rd_req = 1'b0;
        chk("defer_ack_w1", 64'(bus.rd_ack), 64'd0);
        @(negedge clk);
        chk("defer_ack_w2", 64'(bus.rd_ack), 64'd0);
        @(negedge clk);
        chk("defer_ack",  64'(bus.rd_ack),        64'd1);
        chk("defer_err",  64'(bus.rd_err),        64'd0);
        chk("defer_data", 64'(bus.perf_cntr_out), 64'h1234_ABCD);
        @(negedge clk);
        chk("defer_single_ack", 64'(bus.rd_ack), 64'd0);

        // perf_start wins over a same-cycle perf_end
        total_cycle = 64'h0000_0009_0000_0042;
        perf_start = 1'b1; perf_end = 1'b1;
        @(negedge clk);
        perf_start = 1'b0; perf_end = 1'b0;
        chk("start_sv", 64'(snap_valid), 64'd0);
        repeat (3) @(negedge clk);
        chk("start_no_cap", 64'(snap_valid), 64'd0);
        rd(16'h0018, 32'h0000_0300, 1'b0, "start_status");
        rd(16'h001A, 32'h0000_0000, 1'b1, "reserved");
        rd(16'h0018, 32'h0000_0304, 1'b0, "sticky_set");
        rd(16'h0018, 32'h0000_0300, 1'b0, "sticky_clr");
        rd(16'h0000, 32'h0000_0000, 1'b1, "idle_again");

        // Async reset in WAIT with a read pending
        perf_end = 1'b1;
        @(negedge clk); perf_end = 1'b0;
        repeat (2) @(negedge clk);
        chk("sv_cap4", 64'(snap_valid), 64'd1);
        rd(16'h0000, 32'h0000_0042, 1'b0, "cap4_lo");
        perf_end = 1'b1;
        @(negedge clk);
        perf_end = 1'b0; bus.rd_req = 1'b1; bus.operand_in = 16'h0000;
        @(negedge clk);
        bus.rd_req = 1'b0;
        chk("pend_ack", 64'(bus.rd_ack), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_sv",   64'(snap_valid),        64'd0);
        chk("arst_ack",  64'(bus.rd_ack),        64'd0);
        chk("arst_err",  64'(bus.rd_err),        64'd0);
        chk("arst_data", 64'(bus.perf_cntr_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("arst_no_ack", 64'(bus.rd_ack), 64'd0);
        end
        rd(16'h0018, 32'h0000_0000, 1'b0, "arst_status");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
